// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: state, control-field and opcode encodings shared by the control unit
package multicycle_control_unit_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    localparam logic [1:0] ALU_ADD = 2'b00, ALU_BR = 2'b01, ALU_FUNCT = 2'b10, ALU_PASS = 2'b11;
    localparam logic [1:0] WB_MEM = 2'b00, WB_ALU = 2'b01, WB_PC4 = 2'b10;
    localparam logic [1:0] TC_NONE = 2'b00, TC_ILLEGAL = 2'b01, TC_TIMEOUT = 2'b10;
    localparam logic [6:0] OP_OP = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_AUIPC = 7'b0010111, OP_LUI = 7'b0110111;
    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};
    endfunction
    // {alu_op, a_sel, b_sel} driven in EXEC and held through MEM
    function automatic logic [3:0] exec_ctrl(input logic [6:0] op);
        return op == OP_OP ? {ALU_FUNCT, 2'b00} :
               op == OP_IMM ? {ALU_FUNCT, 2'b01} :
               (op == OP_LOAD || op == OP_STORE) ? {ALU_ADD, 2'b01} :
               op == OP_BRANCH ? {ALU_BR, 2'b11} :
               op == OP_JALR ? {ALU_PASS, 2'b01} : {ALU_PASS, 2'b11};
    endfunction
endpackage

// File: rtl/mcu_wait_timer.sv
// mcu_wait_timer: counts memory wait cycles and flags the last one allowed before a bus timeout
module mcu_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
    logic [CW-1:0] wait_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) wait_cnt <= '0;
        else wait_cnt <= clr ? '0 : en ? wait_cnt + CW'(1) : wait_cnt;
    assign timeout = MEM_TIMEOUT != 0 && en && wait_cnt == LAST;
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer over a shared ready-handshaked memory port
// Define MCU_PERF_CNT_EN to build the cycle_cnt/instret performance counters.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode,
    input  logic            mem_ready,
    input  logic            branch_taken,
    output logic [1:0]      alu_op,
    output logic [1:0]      wb_sel,
    output logic            a_sel,
    output logic            b_sel,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ifetch,
    output logic            ir_write,
    output logic            reg_write,
    output logic            pc_write,
    output logic            pc_src,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret
);
    state_t state;
    logic [6:0] op_q;
    logic [1:0] cause_q;
    logic wait_en, tmo, f, ld, st, br, jmp, exm;
    assign wait_en = (state == S_FETCH || state == S_MEM) && !mem_ready;
    mcu_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk(clk), .rst(rst), .clr(!wait_en || tmo), .en(wait_en), .timeout(tmo)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_FETCH;
            op_q <= '0;
            cause_q <= TC_NONE;
        end else begin
            case (state)
                S_FETCH:
                    if (mem_ready) state <= S_DECODE;
                    else if (tmo) begin
                        state <= S_TRAP;
                        cause_q <= TC_TIMEOUT;
                    end
                S_DECODE: begin
                    op_q <= opcode;
                    state <= is_legal(opcode) ? S_EXEC : S_TRAP;
                    if (!is_legal(opcode)) cause_q <= TC_ILLEGAL;
                end
                S_EXEC: state <= (ld || st) ? S_MEM : br ? S_FETCH : S_WB;
                S_MEM:
                    if (mem_ready) state <= ld ? S_WB : S_FETCH;
                    else if (tmo) begin
                        state <= S_TRAP;
                        cause_q <= TC_TIMEOUT;
                    end
                S_WB: state <= S_FETCH;
                default: state <= S_TRAP;
            endcase
        end
    // FETCH requests are masked while rst is held so every output reads 0 during reset
    assign f = state == S_FETCH && !rst;
    assign ld = op_q == OP_LOAD;
    assign st = op_q == OP_STORE;
    assign br = op_q == OP_BRANCH;
    assign jmp = op_q == OP_JAL || op_q == OP_JALR;
    assign exm = state == S_EXEC || state == S_MEM;
    assign {alu_op, a_sel, b_sel} = exm ? exec_ctrl(op_q) : 4'b0;
    assign wb_sel = state == S_WB ? (ld ? WB_MEM : jmp ? WB_PC4 : WB_ALU) : WB_MEM;
    assign mem_read = f || (state == S_MEM && ld);
    assign mem_write = state == S_MEM && st;
    assign ifetch = f;
    assign ir_write = f && mem_ready;
    assign reg_write = state == S_WB;
    assign pc_write = state == S_WB || (state == S_EXEC && br) || (state == S_MEM && st && mem_ready);
    assign pc_src = (state == S_WB && jmp) || (state == S_EXEC && br && branch_taken);
    assign trap = state == S_TRAP;
    assign trap_cause = cause_q;
`ifdef MCU_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cycle_cnt <= '0;
            instret <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + XLEN'(state != S_TRAP);
            instret <= instret + XLEN'(pc_write);
        end
`else
    assign cycle_cnt = '0;
    assign instret = '0;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: random instruction stream checked cycle-by-cycle against an instruction-level scoreboard
module tb_multicycle_control_unit;
    localparam int TO = 4;
    localparam int XLEN = 32;
    localparam logic [6:0] OP = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;
    logic clk = 0, rst = 1;
    logic [6:0] opcode = '0;
    logic mem_ready = 0, branch_taken = 0;
    logic [1:0] alu_op, wb_sel, trap_cause;
    logic a_sel, b_sel, mem_read, mem_write, ifetch, ir_write, reg_write, pc_write, pc_src, trap;
    logic [XLEN-1:0] cycle_cnt, instret;

    multicycle_control_unit #(.XLEN(XLEN), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .alu_op(alu_op), .wb_sel(wb_sel), .a_sel(a_sel), .b_sel(b_sel), .mem_read(mem_read),
        .mem_write(mem_write), .ifetch(ifetch), .ir_write(ir_write), .reg_write(reg_write),
        .pc_write(pc_write), .pc_src(pc_src), .trap(trap), .trap_cause(trap_cause),
        .cycle_cnt(cycle_cnt), .instret(instret)
    );
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] alu_op, wb_sel;
        logic a_sel, b_sel, mem_read, mem_write, ifetch, ir_write, reg_write, pc_write, pc_src, trap;
        logic [1:0] trap_cause;
    } ov_t;
    ov_t act;
    assign act = {alu_op, wb_sel, a_sel, b_sel, mem_read, mem_write, ifetch, ir_write,
                  reg_write, pc_write, pc_src, trap, trap_cause};

    ov_t q_exp[$];
    string q_tag[$];
    int vectors = 0, errors = 0;
    logic [XLEN-1:0] mc = '0, mi = '0;
    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111};

    task automatic check(input string tag, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, a, e);
        end
    endtask

    function automatic bit legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1;
        return 0;
    endfunction
    // {alu_op, a_sel, b_sel} from the opcode table
    function automatic logic [3:0] ctrl_of(input logic [6:0] op);
        case (op)
            7'b0110011: return 4'b10_0_0;
            7'b0010011: return 4'b10_0_1;
            7'b0000011, 7'b0100011: return 4'b00_0_1;
            7'b1100011: return 4'b01_1_1;
            7'b1100111: return 4'b11_0_1;
            default: return 4'b11_1_1;
        endcase
    endfunction
    function automatic logic rnd1();
        return 1'($urandom_range(1));
    endfunction
    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction
    function automatic ov_t vfetch(input logic ir);
        ov_t v = '0;
        v.mem_read = 1;
        v.ifetch = 1;
        v.ir_write = ir;
        return v;
    endfunction
    function automatic ov_t vtrap(input logic [1:0] c);
        ov_t v = '0;
        v.trap = 1;
        v.trap_cause = c;
        return v;
    endfunction

    always @(negedge clk) begin : mon
        ov_t e;
        string t;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            check(t, 64'(act), 64'(e));
`ifdef MCU_PERF_CNT_EN
            check({t, " cycle_cnt"}, 64'(cycle_cnt), 64'(mc));
            check({t, " instret"}, 64'(instret), 64'(mi));
`else
            check({t, " cycle_cnt"}, 64'(cycle_cnt), 64'(0));
            check({t, " instret"}, 64'(instret), 64'(0));
`endif
            mc += XLEN'(!e.trap);
            mi += XLEN'(e.pc_write);
        end
    end

    // Entered and left at posedge+1; inputs hold for the cycle whose expected outputs are queued
    task automatic cyc(input logic rdy, input logic bt, input logic [6:0] op, input ov_t e, input string tag);
        mem_ready = rdy;
        branch_taken = bt;
        opcode = op;
        q_exp.push_back(e);
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic trap_run(input logic [1:0] c, input int n);
        for (int k = 0; k < n; k++) cyc(rnd1(), rnd1(), rop(), vtrap(c), "trap");
    endtask

    // A phase with `waits` not-ready cycles times out once waits reaches TO
    task automatic mem_phase(input int waits, input ov_t wv, input ov_t rv, input string tag, output bit timed_out);
        timed_out = waits >= TO;
        for (int k = 0; k < (timed_out ? TO : waits); k++) cyc(0, rnd1(), rop(), wv, tag);
        if (!timed_out) cyc(1, rnd1(), rop(), rv, tag);
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic bt,
                             input int cut, output bit trapped);
        ov_t v, rv;
        bit tmo, ld, st, br, jmp;
        ld = op == LD;
        st = op == ST;
        br = op == BR;
        jmp = op == 7'b1101111 || op == 7'b1100111;
        trapped = 0;
        mem_phase(fw, vfetch(0), vfetch(1), "fetch", tmo);
        if (tmo) begin
            trapped = 1;
            trap_run(2'b10, 5);
            return;
        end
        cyc(rnd1(), rnd1(), op, '0, "decode");
        if (!legal(op)) begin
            trapped = 1;
            trap_run(2'b01, 20);
            return;
        end
        v = '0;
        {v.alu_op, v.a_sel, v.b_sel} = ctrl_of(op);
        v.pc_write = br;
        v.pc_src = br && bt;
        cyc(rnd1(), bt, rop(), v, br ? (bt ? "exec br taken" : "exec br not") : "exec");
        if (br) return;
        if (ld || st) begin
            v.mem_read = ld;
            v.mem_write = st;
            if (cut > 0) begin
                for (int k = 0; k < cut; k++) cyc(0, rnd1(), rop(), v, "mem cut");
                return;
            end
            rv = v;
            rv.pc_write = st;
            mem_phase(mw, v, rv, "mem", tmo);
            if (tmo) begin
                trapped = 1;
                trap_run(2'b10, 5);
                return;
            end
            if (st) return;
        end
        v = '0;
        v.reg_write = 1;
        v.pc_write = 1;
        v.wb_sel = ld ? 2'b00 : jmp ? 2'b10 : 2'b01;
        v.pc_src = jmp;
        cyc(rnd1(), rnd1(), rop(), v, "wb");
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        #2 rst = 1;
        #1;
        check("async reset outputs", 64'(act), 64'(0));
        check("async reset cycle_cnt", 64'(cycle_cnt), 64'(0));
        check("async reset instret", 64'(instret), 64'(0));
        mc = '0;
        mi = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit tr;
        logic [6:0] op;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 64'(act), 64'(0));
        rst = 0;
        run_instr(OP, 0, 0, 0, 0, tr);
        run_instr(LD, 2, 3, 0, 0, tr);
        run_instr(BR, 0, 0, 1, 0, tr);
        run_instr(BR, 0, 0, 0, 0, tr);
        run_instr(ST, 3, 3, 0, 0, tr);
        for (int i = 0; i < 200; i++)
            run_instr(legal_ops[$urandom_range(8)], $urandom_range(3), $urandom_range(3), rnd1(), 0, tr);
        run_instr(7'b1111111, 0, 0, 0, 0, tr);
        do_reset();
        run_instr(ST, 0, TO, 0, 0, tr);
        do_reset();
        run_instr(OP, TO, 0, 0, 0, tr);
        do_reset();
        run_instr(LD, 1, 0, 0, 2, tr);
        do_reset();
        run_instr(OP, 0, 0, 0, 0, tr);
        for (int i = 0; i < 4; i++) begin
            do op = rop(); while (legal(op));
            run_instr(op, $urandom_range(3), 0, 0, 0, tr);
            do_reset();
        end
        run_instr(LD, 0, 0, 0, 0, tr);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
